deinterleaver_ctrl: RTL and testbench

Sequencing controller for the 12-branch convolutional (Forney, I=12, M=17) byte deinterleaver datapath. It owns the branch commutator (`sel`) and the per-branch shift enables, and aligns branch 0 to the 0x47 sync byte. It tracks pipeline fill (2244 bytes) and sync loss, and flags valid, packet-aligned output bytes. It sits between the demodulator byte stream and the demux/register-buffer/mux datapath, replacing its free-running mod-12 counter and decoder.

---
 rtl/deint_pkg.sv | 19 +
 rtl/deint_sync_det.sv | 16 +
 rtl/deinterleaver_ctrl.sv | 139 +++++++++++++
 tb/tb_deinterleaver_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deint_pkg.sv
// Shared constants and state type for the convolutional deinterleaver controller.
package deint_pkg;

  localparam int unsigned DEINT_BRANCHES = 12;
  localparam int unsigned DEINT_M        = 17;
  localparam int unsigned DEINT_PKT_LEN  = DEINT_BRANCHES * DEINT_M;
  localparam int unsigned DEINT_FILL_LEN = (DEINT_BRANCHES - 1) * DEINT_BRANCHES * DEINT_M;

  localparam logic [7:0] DEINT_SYNC     = 8'h47;
  localparam logic [7:0] DEINT_SYNC_INV = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_FILL,
    ST_RUN
  } deint_state_e;

endpackage

// File: rtl/deint_sync_det.sv
// Combinational MPEG-TS sync byte detector.
// With DEINT_INV_SYNC_EN defined, the inverted sync byte 0xB8 also matches.
module deint_sync_det
  import deint_pkg::*;
(
  input  logic [7:0] data,
  output logic       hit
);

`ifdef DEINT_INV_SYNC_EN
  assign hit = (data == DEINT_SYNC) || (data == DEINT_SYNC_INV);
`else
  assign hit = (data == DEINT_SYNC);
`endif

endmodule

// File: rtl/deinterleaver_ctrl.sv
// Commutator, fill and sync-lock sequencer for the I=12, M=17 byte deinterleaver.
// Optional feature macro: DEINT_INV_SYNC_EN (accept 0xB8 as sync, handled in deint_sync_det).
module deinterleaver_ctrl
  import deint_pkg::*;
#(
  parameter int unsigned BRANCHES = DEINT_BRANCHES,
  parameter int unsigned M        = DEINT_M,
  parameter int unsigned PKT_LEN  = DEINT_PKT_LEN,   // must equal BRANCHES*M
  parameter int unsigned MISS_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [10:0] buf_en,
  output logic        out_valid,
  output logic        out_sop,
  output logic        locked,
  output logic        fill_done
);

  localparam int unsigned FILL_LEN = (BRANCHES - 1) * BRANCHES * M;
  localparam int unsigned PKT_W    = $clog2(PKT_LEN);
  localparam int unsigned FILL_W   = 12;
  localparam int unsigned MISS_W   = $clog2(MISS_MAX + 1);
  localparam logic [3:0]  SEL_LAST = 4'(BRANCHES - 1);

  deint_state_e      state, state_nxt;
  logic [3:0]        sel_nxt;
  logic [PKT_W-1:0]  pkt_cnt, pkt_nxt;
  logic [FILL_W-1:0] fill_cnt, fill_nxt;
  logic [MISS_W-1:0] miss_cnt, miss_nxt;
  logic              step;
  logic              sync_hit;

  deint_sync_det u_sync_det (
    .data (in_data),
    .hit  (sync_hit)
  );

  // NOTE: every output and next-state value gets a default before the case
  // statement, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    pkt_nxt   = pkt_cnt;
    fill_nxt  = fill_cnt;
    miss_nxt  = miss_cnt;
    buf_en    = '0;

    in_ready  = (state != ST_IDLE) && out_ready;
    step      = in_valid && in_ready;
    out_valid = step && (state == ST_RUN);
    out_sop   = out_valid && (pkt_cnt == '0);

    unique case (state)
      ST_IDLE: state_nxt = ST_ALIGN;

      ST_ALIGN: begin
        // The sync byte itself is branch 0 of the first packet.
        if (step && sync_hit) begin
          buf_en    = 11'h001;
          sel_nxt   = 4'd1;
          pkt_nxt   = PKT_W'(1);
          fill_nxt  = FILL_W'(1);
          miss_nxt  = '0;
          state_nxt = ST_FILL;
        end
      end

      ST_FILL, ST_RUN: begin
        if (step) begin
          if (sel < SEL_LAST) buf_en = 11'(1) << sel;
          sel_nxt = (sel == SEL_LAST) ? 4'd0 : sel + 4'd1;
          pkt_nxt = (pkt_cnt == PKT_W'(PKT_LEN - 1)) ? '0 : pkt_cnt + PKT_W'(1);

          // fill_cnt holds once RUN is reached.
          if (state == ST_FILL) begin
            fill_nxt = fill_cnt + FILL_W'(1);
            if (fill_cnt == FILL_W'(FILL_LEN - 1)) state_nxt = ST_RUN;
          end

          if (pkt_cnt == '0) begin
            if (sync_hit) begin
              miss_nxt = '0;
            end else if (miss_cnt == MISS_W'(MISS_MAX - 1)) begin
              // Loss of lock; this byte is still written above.
              state_nxt = ST_ALIGN;
              sel_nxt   = '0;
              pkt_nxt   = '0;
              fill_nxt  = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Disable overrides everything, including a simultaneous loss of lock.
    if (!enable) begin
      state_nxt = ST_IDLE;
      sel_nxt   = '0;
      pkt_nxt   = '0;
      fill_nxt  = '0;
      miss_nxt  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      pkt_cnt   <= '0;
      fill_cnt  <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      pkt_cnt   <= pkt_nxt;
      fill_cnt  <= fill_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == ST_FILL) || (state_nxt == ST_RUN);
      fill_done <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_deinterleaver_ctrl.sv
// Self-checking bench for deinterleaver_ctrl: random valid/ready stimulus against a
// byte-count reference model. Honours DEINT_INV_SYNC_EN when compiled with it.
module tb_deinterleaver_ctrl;

  localparam int BR   = 12;
  localparam int PL   = 204;
  localparam int FILL = (BR - 1) * PL;   // 2244 bytes of pipeline fill
`ifdef DEINT_INV_SYNC_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_sop, locked, fill_done;
  logic [3:0]  sel;
  logic [10:0] buf_en;

  deinterleaver_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .sel       (sel),
    .buf_en    (buf_en),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .locked    (locked),
    .fill_done (fill_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes accepted since the sync byte (sync = byte 1) and misses.
  bit m_active, m_locked;
  int m_n, m_miss;

  function automatic bit is_sync(input logic [7:0] b);
    return (b == 8'h47) || (INV_EN && b == 8'hB8);
  endfunction

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_n = 0; m_miss = 0;
  endtask

  // Stream generator and observation state.
  int          cyc = 0;
  int          tx_pos = 0;
  logic [7:0]  hdr_q[$];
  bit          last_step;
  int          first_ov = -1;
  logic        first_sop;
  int          sop_gap = 0;
  bit          sop_seen = 0;

  function automatic logic [7:0] payload();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h47 || b == 8'hB8);
    return b;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    logic        exp_rdy, stp, exp_ov, exp_sop;
    logic [3:0]  exp_sel;
    logic [10:0] exp_buf;
    int          br;
    in_valid = v; in_data = d; out_ready = r;
    if (!reset) model_reset();
    #2;
    exp_rdy = m_active && r;
    stp     = v && exp_rdy;
    br      = m_n % BR;
    exp_sel = m_locked ? 4'(br) : 4'd0;
    exp_buf = '0;
    if (stp && !m_locked && is_sync(d)) exp_buf = 11'h001;
    if (stp && m_locked && br < BR - 1) exp_buf = 11'(1) << br;
    exp_ov  = stp && m_locked && (m_n >= FILL);
    exp_sop = exp_ov && (m_n % PL == 0);

    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("buf_en",    32'(buf_en),    32'(exp_buf));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("out_sop",   32'(out_sop),   32'(exp_sop));
    check("sel",       32'(sel),       32'(exp_sel));
    check("locked",    32'(locked),    32'(m_locked));
    check("fill_done", 32'(fill_done), 32'(m_locked && m_n >= FILL));

    if (out_valid && first_ov < 0) begin
      first_ov  = cyc;
      first_sop = out_sop;
    end
    if (!locked) sop_seen = 0;
    if (out_valid) begin
      if (out_sop) begin
        if (sop_seen) check("sop_spacing", 32'(sop_gap), 32'(PL));
        sop_gap  = 0;
        sop_seen = 1;
      end
      sop_gap++;
    end
    last_step = stp;

    @(posedge clk);
    #1;
    cyc++;
    if (!reset || !enable) begin
      model_reset();
    end else if (!m_active) begin
      m_active = 1;
    end else if (stp) begin
      if (!m_locked) begin
        if (is_sync(d)) begin
          m_locked = 1; m_n = 1; m_miss = 0;
        end
      end else begin
        if (m_n % PL == 0) m_miss = is_sync(d) ? 0 : m_miss + 1;
        if (m_miss == 3) begin
          m_locked = 0; m_n = 0; m_miss = 0;
        end else begin
          m_n++;
        end
      end
    end
  endtask

  // One cycle of stream traffic; vp/rp are valid/ready probabilities in percent.
  task automatic send1(input int vp, input int rp);
    logic       v, r;
    logic [7:0] d, dummy;
    v = ($urandom_range(0, 99) < vp);
    r = ($urandom_range(0, 99) < rp);
    if (tx_pos == 0) d = (hdr_q.size() > 0) ? hdr_q[0] : 8'h47;
    else             d = payload();
    drive(v, d, r);
    if (last_step) begin
      if (tx_pos == 0 && hdr_q.size() > 0) dummy = hdr_q.pop_front();
      tx_pos = (tx_pos + 1) % PL;
    end
  endtask

  task automatic drain_headers(input int vp, input int rp);
    for (int i = 0; i < 3000 && hdr_q.size() > 0; i++) send1(vp, rp);
    check("hdr_drain_timeout", 32'(hdr_q.size()), 32'd0);
  endtask

  int sync_cyc;

  initial begin
    reset = 1'b0; enable = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();

    // Reset values, with inputs that would otherwise step.
    repeat (3) drive(1'b1, 8'h47, 1'b1);

    reset = 1'b1; enable = 1'b1;
    drive(1'b0, 8'h00, 1'b1);        // still IDLE this cycle
    drive(1'b0, 8'h00, 1'b1);        // ALIGN: in_ready follows out_ready
    drive(1'b0, 8'h00, 1'b0);

    // Acquire: 5 non-sync bytes, then 0x47.
    tx_pos = PL - 5;
    repeat (5) send1(100, 100);
    sync_cyc = cyc;
    first_ov = -1;
    send1(100, 100);
    check("acq_sel", 32'(sel), 32'd1);
    check("acq_locked", 32'(locked), 32'd1);

    // Fill with a 10-cycle backpressure stall.
    repeat (1000) send1(100, 100);
    repeat (10) send1(100, 0);
    check("stall_sel", 32'(sel), 32'(1001 % BR));
    check("stall_fill_done", 32'(fill_done), 32'd0);
    for (int i = 0; i < 3000 && first_ov < 0; i++) send1(100, 100);
    check("first_ov_latency", 32'(first_ov - sync_cyc), 32'(FILL + 10));
    check("first_ov_sop", 32'(first_sop), 32'd1);
    check("run_fill_done", 32'(fill_done), 32'd1);

    // Random flow in RUN.
    repeat (700) send1(80, 80);

    // Two bad headers then a good one: lock holds.
    hdr_q.push_back(payload());
    hdr_q.push_back(payload());
    hdr_q.push_back(8'h47);
    drain_headers(90, 90);
    check("two_miss_run", 32'(fill_done), 32'd1);

    // Three bad headers: back to ALIGN.
    repeat (3) hdr_q.push_back(payload());
    drain_headers(90, 90);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_sel", 32'(sel), 32'd0);

    // Re-acquire and refill.
    repeat (2600) send1(100, 100);
    check("refill_done", 32'(fill_done), 32'd1);

    // Inverted sync headers: only tolerated when the option is built in.
    repeat (3) hdr_q.push_back(8'hB8);
    drain_headers(100, 100);
    check("inv_sync_locked", 32'(locked), 32'(INV_EN));
    repeat (300) send1(80, 80);

    // Enable drop returns to IDLE.
    enable = 1'b0;
    send1(100, 100);
    check("dis_locked", 32'(locked), 32'd0);
    check("dis_sel", 32'(sel), 32'd0);
    enable = 1'b1;
    repeat (300) send1(90, 90);

    // Asynchronous reset mid-operation.
    reset = 1'b0;
    repeat (2) send1(100, 100);
    check("rst_locked", 32'(locked), 32'd0);
    reset = 1'b1;
    repeat (20) send1(100, 100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
